// File: rtl/abacus_pkg.sv
// Shared definitions for the abacus profiling block: scheduler state encoding,
// profiling-unit indices and scheduler register offsets.
package abacus_pkg;

    localparam int unsigned DEF_NUM_UNITS = 2;
    localparam int unsigned DEF_WIN_W     = 32;
    localparam int unsigned DEF_NWIN_W    = 16;
    localparam int unsigned STATE_W       = 3;

    localparam int unsigned UNIT_INSTR = 0;
    localparam int unsigned UNIT_CACHE = 1;

    localparam int unsigned REG_OFF_W = 8;
    localparam logic [REG_OFF_W-1:0] REG_SCHED_CTRL    = 8'h00;
    localparam logic [REG_OFF_W-1:0] REG_SCHED_WIN_LEN = 8'h04;
    localparam logic [REG_OFF_W-1:0] REG_SCHED_WIN_CNT = 8'h08;
    localparam logic [REG_OFF_W-1:0] REG_SCHED_STATUS  = 8'h0C;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_SNAP  = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/abacus_window_counter.sv
// Loadable down-counter timing one sampling window; saturates at zero.
module abacus_window_counter #(
    parameter int unsigned WIN_W = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic             dec_en,
    input  logic [WIN_W-1:0] load_val,
    output logic             zero_c
);

    logic [WIN_W-1:0] count;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec_en && (count != '0)) begin
            count <= count - WIN_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/abacus_sample_scheduler.sv
// Sequences profiling units through clear/run/snapshot windows.
// Optional build macro ABACUS_SCHED_FREERUN_EN: no HOLD back-pressure, sticky snap_overrun.
module abacus_sample_scheduler
    import abacus_pkg::*;
#(
    parameter int unsigned NUM_UNITS = DEF_NUM_UNITS,
    parameter int unsigned WIN_W     = DEF_WIN_W,
    parameter int unsigned NWIN_W    = DEF_NWIN_W
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic [WIN_W-1:0]     cfg_window_len,
    input  logic [NWIN_W-1:0]    cfg_num_windows,
    input  logic [NUM_UNITS-1:0] cfg_unit_mask,
    input  logic                 snap_ack,
    output logic [NUM_UNITS-1:0] prof_enable,
    output logic                 prof_clear,
    output logic                 snap_strobe,
    output logic                 busy,
    output logic                 done,
    output logic [NWIN_W-1:0]    windows_completed,
    output logic                 snap_overrun,
    output logic [STATE_W-1:0]   state_o
);

    sched_state_t         state;
    logic [WIN_W-1:0]     sh_len;
    logic [NWIN_W-1:0]    sh_num;
    logic [NUM_UNITS-1:0] sh_mask;
    logic                 stop_req;
    logic                 snap_pending;

    logic                 win_zero_c;
    logic [WIN_W-1:0]     win_reload_c;
    logic                 run_end_c;
    logic                 hold_c;
    logic                 last_win_c;

    // A zero length runs a single-cycle window.
    assign win_reload_c = (sh_len == '0) ? '0 : sh_len - WIN_W'(1);

    abacus_window_counter #(
        .WIN_W (WIN_W)
    ) u_win_cnt (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (state == ST_CLEAR),
        .dec_en   (state == ST_RUN),
        .load_val (win_reload_c),
        .zero_c   (win_zero_c)
    );

    assign run_end_c  = win_zero_c || cfg_stop || stop_req;
    assign last_win_c = (sh_num != '0) && (windows_completed == sh_num);

`ifdef ABACUS_SCHED_FREERUN_EN
    assign hold_c = 1'b0;
`else
    // An ack arriving on the exit cycle releases the previous snapshot in time.
    assign hold_c = snap_pending && !snap_ack;
`endif

    assign state_o = state;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state             <= ST_IDLE;
            sh_len            <= '0;
            sh_num            <= '0;
            sh_mask           <= '0;
            stop_req          <= 1'b0;
            snap_pending      <= 1'b0;
            prof_enable       <= '0;
            prof_clear        <= 1'b0;
            snap_strobe       <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            windows_completed <= '0;
            snap_overrun      <= 1'b0;
        end else begin
            prof_clear  <= 1'b0;
            snap_strobe <= 1'b0;

            // Strobe sets pending even when acked in the same cycle.
            if (state == ST_SNAP) begin
                snap_pending <= 1'b1;
            end else if (snap_ack) begin
                snap_pending <= 1'b0;
            end

            if (busy && cfg_stop) begin
                stop_req <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (cfg_start) begin
                        sh_len            <= cfg_window_len;
                        sh_num            <= cfg_num_windows;
                        sh_mask           <= cfg_unit_mask;
                        windows_completed <= '0;
                        done              <= 1'b0;
                        snap_overrun      <= 1'b0;
                        stop_req          <= 1'b0;
                        busy              <= 1'b1;
                        prof_clear        <= 1'b1;
                        state             <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    prof_enable <= sh_mask;
                    state       <= ST_RUN;
                end
                ST_RUN: begin
                    if (run_end_c) begin
                        prof_enable <= '0;
                        if (hold_c) begin
                            state <= ST_HOLD;
                        end else begin
                            snap_strobe       <= 1'b1;
                            windows_completed <= windows_completed + NWIN_W'(1);
                            state             <= ST_SNAP;
                        end
                    end
                end
                ST_HOLD: begin
                    if (snap_ack || !snap_pending) begin
                        snap_strobe       <= 1'b1;
                        windows_completed <= windows_completed + NWIN_W'(1);
                        state             <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
`ifdef ABACUS_SCHED_FREERUN_EN
                    if (snap_pending) begin
                        snap_overrun <= 1'b1;
                    end
`endif
                    if (stop_req || cfg_stop || last_win_c) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        prof_clear <= 1'b1;
                        state      <= ST_CLEAR;
                    end
                end
                default: begin
                    prof_enable <= '0;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abacus_sample_scheduler.sv
// Self-checking bench for abacus_sample_scheduler against a window-timeline model.
module tb_abacus_sample_scheduler;

`ifdef ABACUS_SCHED_FREERUN_EN
    localparam bit FREERUN = 1'b1;
`else
    localparam bit FREERUN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [31:0] cfg_window_len = '0;
    logic [15:0] cfg_num_windows = '0;
    logic [1:0]  cfg_unit_mask = '0;
    logic        snap_ack = 1'b0;
    logic [1:0]  prof_enable;
    logic        prof_clear;
    logic        snap_strobe;
    logic        busy;
    logic        done;
    logic [15:0] windows_completed;
    logic        snap_overrun;
    logic [2:0]  state_o;

    int checks = 0;
    int failures = 0;

    abacus_sample_scheduler dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .cfg_start         (cfg_start),
        .cfg_stop          (cfg_stop),
        .cfg_window_len    (cfg_window_len),
        .cfg_num_windows   (cfg_num_windows),
        .cfg_unit_mask     (cfg_unit_mask),
        .snap_ack          (snap_ack),
        .prof_enable       (prof_enable),
        .prof_clear        (prof_clear),
        .snap_strobe       (snap_strobe),
        .busy              (busy),
        .done              (done),
        .windows_completed (windows_completed),
        .snap_overrun      (snap_overrun),
        .state_o           (state_o)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int en, input bit clr,
                           input bit stb, input bit bsy, input bit dn, input int wc, input bit ovr);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".enable"}, 32'(prof_enable), 32'(en));
        chk({tag, ".clear"}, 32'(prof_clear), 32'(clr));
        chk({tag, ".strobe"}, 32'(snap_strobe), 32'(stb));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".wcomp"}, 32'(windows_completed), 32'(wc));
        chk({tag, ".overrun"}, 32'(snap_overrun), 32'(ovr));
    endtask

    // Release any outstanding snapshot while idle so the next run starts clean.
    task automatic idle_ack();
        snap_ack = 1'b1;
        tick();
        snap_ack = 1'b0;
    endtask

    // Each window is one clear cycle, max(len,1) enable cycles and one strobe cycle;
    // after num windows the run sits in DONE. ack=1 acks every snapshot on the next cycle.
    task automatic run_trace(input string name, input int len, input int num, input int mask,
                             input bit ack, input int ncyc, input int poke, input bit with_stop);
        int  wl;
        int  per;
        bit  prev_stb;
        wl = (len == 0) ? 1 : len;
        per = wl + 2;
        prev_stb = 1'b0;
        cfg_window_len  = 32'(len);
        cfg_num_windows = 16'(num);
        cfg_unit_mask   = 2'(mask);
        cfg_start = 1'b1;
        cfg_stop  = with_stop;
        tick();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            int  w;
            int  p;
            int  e_st;
            int  e_en;
            int  e_wc;
            bit  e_clr;
            bit  e_stb;
            bit  e_bsy;
            bit  e_dn;
            bit  e_ovr;
            snap_ack = ack && prev_stb;
            if (poke != 0 && c == poke) begin
                cfg_start       = 1'b1;
                cfg_window_len  = 32'd1;
                cfg_num_windows = 16'd9;
                cfg_unit_mask   = ~(2'(mask));
            end else begin
                cfg_start = 1'b0;
            end
            w = (c - 1) / per;
            p = (c - 1) % per;
            if (num != 0 && c == num * per + 1) begin
                e_st = 5; e_en = 0; e_clr = 0; e_stb = 0; e_bsy = 0; e_dn = 1; e_wc = num;
                e_ovr = FREERUN && !ack && (num >= 2);
            end else begin
                e_clr = (p == 0);
                e_stb = (p == wl + 1);
                e_en  = (p >= 1 && p <= wl) ? mask : 0;
                e_st  = (p == 0) ? 1 : ((p <= wl) ? 2 : 4);
                e_bsy = 1'b1;
                e_dn  = 1'b0;
                e_wc  = (w + (e_stb ? 1 : 0)) % 65536;
                e_ovr = FREERUN && !ack && (w >= 2);
            end
            chk_all($sformatf("%s.c%0d", name, c), e_st, e_en, e_clr, e_stb, e_bsy, e_dn, e_wc, e_ovr);
            prev_stb = e_stb;
            if (c < ncyc) tick();
        end
        cfg_start = 1'b0;
    endtask

    initial begin
        int len;
        int num;
        int mask;
        int ncyc;
        int poke;

        // Reset state
        aresetn = 1'b0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        aresetn = 1'b1;
        tick();
        chk("post_reset.state", 32'(state_o), 32'd0);

        // Stop alone in IDLE is ignored
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        chk("idle_stop.state", 32'(state_o), 32'd0);
        chk("idle_stop.busy", 32'(busy), 32'd0);

        // Single 4-cycle window, started together with a (dropped) stop
        run_trace("t1", 4, 1, 3, 1'b0, 7, 0, 1'b1);
        idle_ack();

        // Zero-length windows without acks
`ifdef ABACUS_SCHED_FREERUN_EN
        run_trace("t2", 0, 2, 3, 1'b0, 7, 0, 1'b0);
        idle_ack();
`else
        run_trace("t2", 0, 2, 3, 1'b0, 5, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all($sformatf("t2.hold%0d", i), 3, 0, 0, 0, 1, 0, 1, 0);
        end
        snap_ack = 1'b1;
        tick();
        snap_ack = 1'b0;
        chk_all("t2.snap", 4, 0, 0, 1, 1, 0, 2, 0);
        tick();
        chk_all("t2.done", 5, 0, 0, 0, 0, 1, 2, 0);
        idle_ack();
`endif

        // Continuous mode, stopped mid-RUN of the third window
        run_trace("t3", 3, 0, 1, 1'b1, 12, 0, 1'b0);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        chk_all("t3.stop_snap", 4, 0, 0, 1, 1, 0, 3, 0);
        tick();
        chk_all("t3.done", 5, 0, 0, 0, 0, 1, 3, 0);
        idle_ack();

        // Start and config changes during RUN have no effect
        run_trace("t4", 4, 2, 2, 1'b1, 13, 3, 1'b0);
        idle_ack();

`ifdef ABACUS_SCHED_FREERUN_EN
        // Free-running windows without acks overrun on the second strobe
        run_trace("t6", 2, 3, 3, 1'b0, 13, 0, 1'b0);
        idle_ack();
`endif

        // Randomized runs with acked snapshots and a stray start mid-run
        for (int i = 0; i < 4; i++) begin
            len  = int'($urandom_range(0, 6));
            num  = int'($urandom_range(1, 3));
            mask = int'($urandom_range(0, 3));
            ncyc = num * (((len == 0) ? 1 : len) + 2) + 1;
            poke = int'($urandom_range(2, ncyc - 1));
            run_trace($sformatf("rnd%0d", i), len, num, mask, 1'b1, ncyc, poke, 1'b0);
            idle_ack();
        end

        // Reset asserted mid-RUN
        run_trace("t5", 100, 1, 3, 1'b0, 10, 0, 1'b0);
        aresetn = 1'b0;
        tick();
        chk_all("t5.rst", 0, 0, 0, 0, 0, 0, 0, 0);
        aresetn = 1'b1;
        tick();
        chk_all("t5.after", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
